// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
// Holds the parity-mode encodings, the receiver state type, the
// oversampling divisor calculation and the majority-of-3 voter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // Rounded clock divisor giving one tick per oversample.
    function automatic int calc_ovs_div(input int clk_freq, input int baud, input int ovs);
        return (clk_freq + (baud * ovs) / 2) / (baud * ovs);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator.
// Emits a one-cycle tick every DIV clocks. i_restart reloads the counter so
// the next tick lands exactly DIV clocks later (phase alignment to an edge).
// Ports:
//   SYS_CLK    in   system clock
//   RST_N      in   asynchronous active-low reset
//   i_restart  in   synchronous phase restart
//   o_tick     out  one-cycle tick
module uart_baud_tick #(
    parameter int DIV = 5
) (
    input  logic SYS_CLK,
    input  logic RST_N,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= RELOAD;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-voted bit recovery.
// Configurable payload width, parity and stop bits; every frame is delivered
// with its parity / framing error flags.
// Ports:
//   SYS_CLK     in   system clock
//   RST_N       in   asynchronous active-low reset
//   RX          in   asynchronous serial line, idle high
//   RX_DATA     out  last payload, LSB first on the wire
//   RX_VALID    out  one-cycle frame-complete pulse
//   PARITY_ERR  out  parity mismatch of last frame
//   FRAME_ERR   out  stop bit sampled low in last frame
//   BUSY        out  receiver not idle
//
// state    | meaning
// S_IDLE   | waiting for a falling edge on the synchronised line
// S_START  | validating the start bit (glitch rejection)
// S_DATA   | shifting in payload bits, LSB first
// S_PARITY | checking the parity bit
// S_STOP   | checking stop bit(s); frame delivered mid last stop bit
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 20_000_000,
    parameter int BAUD      = 256_000,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 SYS_CLK,
    input  logic                 RST_N,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int OVS_DIV = calc_ovs_div(CLK_FREQ, BAUD, OVS);
    localparam int SW      = $clog2(OVS);
    localparam int BW      = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_SAMP0  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_SAMP1  = SW'(OVS / 2);
    localparam logic [SW-1:0] S_DECIDE = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (OVS_DIV < 1 || (OVS % 2) != 0 || OVS < 8 || OVS > 16 ||
        DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_rx_ovs: illegal parameter set");
    end

    logic r_sync1, r_sync2, r_sync3;

    rx_state_t             r_state;
    logic [SW-1:0]         r_s;
    logic [1:0]            r_samp;
    logic [BW-1:0]         r_bitcnt;
    logic                  r_stopcnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_perr;
    logic                  r_ferr;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic                  r_rx_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_busy;

    logic w_fall, w_restart, w_tick, w_decide, w_end, w_bit, w_par_exp;

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall    = r_sync3 & ~r_sync2;
    assign w_restart = (r_state == S_IDLE) & w_fall;

    uart_baud_tick #(
        .DIV(OVS_DIV)
    ) u_baud_tick (
        .SYS_CLK  (SYS_CLK),
        .RST_N    (RST_N),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    assign w_decide  = w_tick & (r_s == S_DECIDE);
    assign w_end     = w_tick & (r_s == S_LAST);
    // Third vote is the live synchronised sample taken at the decision tick.
    assign w_bit     = maj3(r_samp[0], r_samp[1], r_sync2);
    assign w_par_exp = (^r_shift) ^ (PARITY == PARITY_ODD);

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_s          <= '0;
            r_samp       <= 2'b11;
            r_bitcnt     <= '0;
            r_stopcnt    <= 1'b0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;

            if (w_tick && r_state != S_IDLE) begin
                r_s <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
            end
            if (w_tick && r_s == S_SAMP0) begin
                r_samp[0] <= r_sync2;
            end
            if (w_tick && r_s == S_SAMP1) begin
                r_samp[1] <= r_sync2;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        r_busy    <= 1'b1;
                        // The detected edge counts as sample 0 of the start bit.
                        r_s       <= SW'(1);
                        r_bitcnt  <= '0;
                        r_stopcnt <= 1'b0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_decide && w_bit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_end) begin
                        if (r_bitcnt == BIT_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_decide && (w_bit != w_par_exp)) begin
                        r_perr <= 1'b1;
                    end
                    if (w_end) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        if (r_stopcnt == STOP_LAST) begin
                            // Leave half a bit early so a back-to-back start edge is seen.
                            r_rx_data    <= r_shift;
                            r_parity_err <= r_perr;
                            r_frame_err  <= r_ferr | ~w_bit;
                            r_rx_valid   <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end else if (!w_bit) begin
                            r_ferr <= 1'b1;
                        end
                    end else if (w_end) begin
                        r_stopcnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RX_DATA    = r_rx_data;
    assign RX_VALID   = r_rx_valid;
    assign PARITY_ERR = r_parity_err;
    assign FRAME_ERR  = r_frame_err;
    assign BUSY       = r_busy;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: three instances (8N1, 8E1, 5N2) driven
// from a bit-level frame builder; expectations come from the frame contents.
module tb_uart_rx_ovs;

    localparam int T   = 80;   // clocks per bit: 20 MHz / 256 kbaud, OVS 16, divisor 5
    localparam int DIV = 5;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;

    exp_t q0[$], q1[$], q2[$];
    int checks = 0, errors = 0, anomalies = 0;
    int cyc = 0;
    int t_start[3];
    int seen_busy[3];
    logic [7:0] last_d[3];
    logic last_pe[3], last_fe[3], pv[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ovs #(.CLK_FREQ(20_000_000), .BAUD(256_000), .OVS(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .SYS_CLK(clk), .RST_N(rst_n), .RX(rx0), .RX_DATA(d0), .RX_VALID(v0),
        .PARITY_ERR(pe0), .FRAME_ERR(fe0), .BUSY(b0));

    uart_rx_ovs #(.CLK_FREQ(20_000_000), .BAUD(256_000), .OVS(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .SYS_CLK(clk), .RST_N(rst_n), .RX(rx1), .RX_DATA(d1), .RX_VALID(v1),
        .PARITY_ERR(pe1), .FRAME_ERR(fe1), .BUSY(b1));

    uart_rx_ovs #(.CLK_FREQ(20_000_000), .BAUD(256_000), .OVS(16),
                  .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) dut2 (
        .SYS_CLK(clk), .RST_N(rst_n), .RX(rx2), .RX_DATA(d2), .RX_VALID(v2),
        .PARITY_ERR(pe2), .FRAME_ERR(fe2), .BUSY(b2));

    function automatic int dbits_of(input int idx);
        return (idx == 2) ? 5 : 8;
    endfunction
    function automatic int pmode_of(input int idx);
        return (idx == 1) ? 2 : 0;
    endfunction
    function automatic int nstop_of(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    // Parity bit a correct transmitter would send.
    function automatic logic ref_par(input logic [7:0] data, input int dbits, input int pmode);
        int ones;
        ones = 0;
        for (int i = 0; i < dbits; i++) ones += int'(data[i]);
        return (pmode == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
    endfunction

    // Expected delay from pin falling edge to RX_VALID, in clocks.
    function automatic int ref_latency(input int idx);
        int n;
        n = 1 + dbits_of(idx) + ((pmode_of(idx) != 0) ? 1 : 0) + nstop_of(idx);
        return n * T - T / 2 + DIV + 4;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic drive(input int idx, input logic v);
        case (idx)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic idle(input int idx, input int n);
        repeat (n) begin
            @(negedge clk);
            drive(idx, 1'b1);
        end
    endtask

    task automatic push(input int idx, input exp_t e);
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Builds start/data/parity/stop bits, pushes the expected result, then
    // drives the line. spike_bit >= 0 inverts that frame bit for a few clocks
    // around its centre sample only.
    task automatic send_frame(input int idx, input logic [7:0] data, input logic par_bit,
                              input logic [1:0] stops, input int spike_bit);
        int dbits, pmode, nstop, nb;
        logic [15:0] fb;
        exp_t e;
        logic v;
        dbits = dbits_of(idx);
        pmode = pmode_of(idx);
        nstop = nstop_of(idx);
        fb = '1;
        nb = 0;
        fb[nb] = 1'b0;
        nb++;
        for (int i = 0; i < dbits; i++) begin
            fb[nb] = data[i];
            nb++;
        end
        if (pmode != 0) begin
            fb[nb] = par_bit;
            nb++;
        end
        for (int j = 0; j < nstop; j++) begin
            fb[nb] = stops[j];
            nb++;
        end
        e.data = (dbits == 5) ? (data & 8'h1F) : data;
        e.perr = (pmode != 0) && (par_bit != ref_par(data, dbits, pmode));
        e.ferr = 1'b0;
        for (int j = 0; j < nstop; j++) if (!stops[j]) e.ferr = 1'b1;
        push(idx, e);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < T; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) t_start[idx] = cyc;
                v = fb[b];
                if (b == spike_bit && c >= 37 && c <= 43) v = ~v;
                drive(idx, v);
            end
        end
    endtask

    task automatic on_valid(input int idx, input logic [7:0] data, input logic pe, input logic fe);
        exp_t e;
        logic have;
        int lat;
        have = 1'b0;
        e = '0;
        case (idx)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rx_valid[%0d]: got pulse data %0h expected no pulse", idx, data);
        end else begin
            chk($sformatf("rx_data[%0d]", idx), int'(data), int'(e.data));
            chk($sformatf("parity_err[%0d]", idx), int'(pe), int'(e.perr));
            chk($sformatf("frame_err[%0d]", idx), int'(fe), int'(e.ferr));
            lat = cyc - t_start[idx];
            checks++;
            if (lat < ref_latency(idx) - 1 || lat > ref_latency(idx) + 1) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d expected %0d +-1", idx, lat, ref_latency(idx));
            end
        end
    endtask

    task automatic mon(input int idx, input logic v, input logic [7:0] data,
                       input logic pe, input logic fe, input logic busy);
        if (!rst_n) begin
            last_d[idx] = '0;
            last_pe[idx] = 1'b0;
            last_fe[idx] = 1'b0;
            pv[idx] = 1'b0;
        end else begin
            if (busy) seen_busy[idx] = 1;
            if (v) begin
                if (pv[idx]) anomalies++;
                on_valid(idx, data, pe, fe);
            end else if (data != last_d[idx] || pe != last_pe[idx] || fe != last_fe[idx]) begin
                anomalies++;
            end
            last_d[idx] = data;
            last_pe[idx] = pe;
            last_fe[idx] = fe;
            pv[idx] = v;
        end
    endtask

    always @(negedge clk) begin
        mon(0, v0, d0, pe0, fe0, b0);
        mon(1, v1, d1, pe1, fe1, b1);
        mon(2, v2, {3'b000, d2}, pe2, fe2, b2);
    end

    initial begin
        int idx, gap, nstop;
        logic [7:0] data;
        logic [1:0] stops;
        logic par;

        for (int i = 0; i < 3; i++) begin
            t_start[i] = 0;
            seen_busy[i] = 0;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rx_data0", int'(d0), 0);
        chk("reset_rx_valid0", int'(v0), 0);
        chk("reset_parity_err0", int'(pe0), 0);
        chk("reset_frame_err0", int'(fe0), 0);
        chk("reset_busy0", int'(b0), 0);
        chk("reset_rx_data2", int'(d2), 0);

        // Nominal 8N1 frame.
        send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
        idle(0, 20);
        chk("busy_after_a5", int'(b0), 0);

        // Framing error followed by a break: only one pulse until a fresh edge.
        send_frame(0, 8'h55, 1'b0, 2'b00, -1);
        for (int c = 0; c < 3 * T; c++) begin
            @(negedge clk);
            drive(0, 1'b0);
        end
        chk("break_no_busy", int'(b0), 0);
        idle(0, 200);
        send_frame(0, 8'h3A, 1'b0, 2'b11, -1);
        idle(0, 20);

        // Short idle-line glitch is rejected.
        seen_busy[0] = 0;
        for (int c = 0; c < 2 * DIV; c++) begin
            @(negedge clk);
            drive(0, 1'b0);
        end
        idle(0, 200);
        chk("glitch_busy_seen", seen_busy[0], 1);
        chk("glitch_busy_low", int'(b0), 0);
        chk("glitch_data_kept", int'(d0), 8'h3A);

        // Single-sample spike inside data bit 3 (frame bit 4) of 0x00.
        send_frame(0, 8'h00, 1'b0, 2'b11, 4);
        idle(0, 10);

        // Back-to-back frames, no idle gap.
        send_frame(0, 8'h00, 1'b0, 2'b11, -1);
        send_frame(0, 8'hFF, 1'b0, 2'b11, -1);
        send_frame(0, 8'h81, 1'b0, 2'b11, -1);
        idle(0, 20);

        // Reset during data bit 4 of 0xF0.
        for (int c = 0; c < 5 * T + 40; c++) begin
            @(negedge clk);
            drive(0, (c < 5 * T) ? 1'b0 : 1'b1);
        end
        chk("busy_mid_frame", int'(b0), 1);
        chk("data_before_reset", int'(d0), 8'h81);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_data", int'(d0), 0);
        chk("async_reset_busy", int'(b0), 0);
        chk("async_reset_valid", int'(v0), 0);
        chk("async_reset_ferr", int'(fe0), 0);
        repeat (3) @(negedge clk);
        drive(0, 1'b1);
        rst_n = 1'b1;
        idle(0, 20);
        send_frame(0, 8'h0F, 1'b0, 2'b11, -1);
        idle(0, 20);

        // Even parity: wrong then correct parity bit.
        send_frame(1, 8'h3C, 1'b1, 2'b11, -1);
        idle(1, 20);
        send_frame(1, 8'h01, 1'b1, 2'b11, -1);
        idle(1, 20);

        // Five data bits, two stop bits.
        send_frame(2, 8'h13, 1'b0, 2'b11, -1);
        idle(2, 20);

        // Randomised frames across all configurations.
        for (int r = 0; r < 24; r++) begin
            idx = $urandom_range(0, 2);
            data = 8'($urandom);
            par = 1'($urandom_range(0, 1));
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            nstop = nstop_of(idx);
            send_frame(idx, data, par, stops, -1);
            gap = $urandom_range(0, 30);
            if (!stops[nstop-1]) gap += 40;
            idle(idx, gap);
        end

        for (int k = 0; k < 2000 && (q0.size() + q1.size() + q2.size()) != 0; k++) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("pulse_width_and_output_hold", anomalies, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
